// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Build option MC_TRAP_EN (see mc_control_fsm) uses the TRAP state declared here.
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        ADDI_EXEC = 4'd8,
        ADDI_WB   = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Purely combinational Moore decode from controller state to datapath controls.
// FETCH asserts ir_write/pc_write unconditionally; the top gates them with mem_ready.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    // State to control-word decode; anything not listed stays 0.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
            end
            DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH;
            MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            ADDI_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            ADDI_WB: o_ctrl.reg_write = 1'b1;
            BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic, retire counter.
// Define MC_TRAP_EN to trap (sticky, until reset) on illegal opcodes instead of retiring them as NOPs.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [CNT_W-1:0]   r_instr_count;
    logic               r_trap;
    logic               w_in_fetch;
    logic               w_retire;
    ctrl_t              w_ctrl;

    mc_ctrl_decode u_decode (
        .i_state (state_t'(r_state)),
        .o_ctrl  (w_ctrl)
    );

    // Next-state selection; unknown encodings recover to FETCH.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH: begin
                if (mem_ready) w_next_state = DECODE;
                else           w_next_state = FETCH;
            end
            DECODE: begin
                if (is_mem_op(opcode))        w_next_state = MEM_ADDR;
                else if (opcode == OP_RTYPE)  w_next_state = R_EXEC;
                else if (opcode == OP_BEQ)    w_next_state = BRANCH;
                else if (opcode == OP_J)      w_next_state = JUMP;
                else if (opcode == OP_ADDI)   w_next_state = ADDI_EXEC;
`ifdef MC_TRAP_EN
                else                          w_next_state = TRAP;
`else
                else                          w_next_state = FETCH;
`endif
            end
            MEM_ADDR: begin
                if (opcode == OP_SW) w_next_state = MEM_WRITE;
                else                 w_next_state = MEM_READ;
            end
            MEM_READ: begin
                if (mem_ready) w_next_state = MEM_WB;
                else           w_next_state = MEM_READ;
            end
            MEM_WRITE: begin
                if (mem_ready) w_next_state = FETCH;
                else           w_next_state = MEM_WRITE;
            end
            MEM_WB:    w_next_state = FETCH;
            R_EXEC:    w_next_state = R_WB;
            R_WB:      w_next_state = FETCH;
            ADDI_EXEC: w_next_state = ADDI_WB;
            ADDI_WB:   w_next_state = FETCH;
            BRANCH:    w_next_state = FETCH;
            JUMP:      w_next_state = FETCH;
`ifdef MC_TRAP_EN
            TRAP:      w_next_state = TRAP;
`else
            TRAP:      w_next_state = FETCH;
`endif
            default:   w_next_state = FETCH;
        endcase
    end

    assign w_in_fetch = (r_state == FETCH);
    assign w_retire   = !w_in_fetch && (w_next_state == FETCH);

    // State register, retire counter and sticky trap flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= FETCH;
            r_instr_count <= '0;
            r_trap        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
            else          r_instr_count <= r_instr_count;
`ifdef MC_TRAP_EN
            if (w_next_state == TRAP) r_trap <= 1'b1;
            else                      r_trap <= r_trap;
`else
            r_trap <= 1'b0;
`endif
        end
    end

    // The FETCH-time PC increment and IR load only happen once the fetch completes.
    assign pc_en       = (w_ctrl.pc_write & (w_in_fetch ? mem_ready : 1'b1))
                       | (w_ctrl.pc_write_cond & zero);
    assign ir_write    = w_ctrl.ir_write & mem_ready;
    assign i_or_d      = w_ctrl.i_or_d;
    assign mem_read    = w_ctrl.mem_read;
    assign mem_write   = w_ctrl.mem_write;
    assign reg_dst     = w_ctrl.reg_dst;
    assign mem_to_reg  = w_ctrl.mem_to_reg;
    assign reg_write   = w_ctrl.reg_write;
    assign alu_src_a   = w_ctrl.alu_src_a;
    assign alu_src_b   = w_ctrl.alu_src_b;
    assign alu_op      = w_ctrl.alu_op;
    assign pc_source   = w_ctrl.pc_source;
    assign instr_count = r_instr_count;
    assign trap        = r_trap;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction latency/retire scoreboard,
// output checks per scenario, async reset abort, illegal opcode and counter wrap.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] instr_count;
    logic        trap;

    logic        w2_reset;
    logic [5:0]  w2_opcode;
    logic        w2_zero, w2_ready;
    logic        w2_pc_en, w2_i_or_d, w2_mem_read, w2_mem_write, w2_ir_write;
    logic        w2_reg_dst, w2_mem_to_reg, w2_reg_write, w2_alu_src_a;
    logic [1:0]  w2_alu_src_b, w2_alu_op, w2_pc_source;
    logic [2:0]  w2_count;
    logic        w2_trap;

    typedef struct {
        int          cycles;
        logic [31:0] count;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_count;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          saw_rd_wr, saw_mdr_wr, saw_br_pc, saw_j_pc, saw_both_mem;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .instr_count(instr_count), .trap(trap)
    );

    mc_control_fsm #(.CNT_W(3)) u_wrap (
        .clk(clk), .reset(w2_reset), .opcode(w2_opcode), .zero(w2_zero), .mem_ready(w2_ready),
        .pc_en(w2_pc_en), .i_or_d(w2_i_or_d), .mem_read(w2_mem_read), .mem_write(w2_mem_write),
        .ir_write(w2_ir_write), .reg_dst(w2_reg_dst), .mem_to_reg(w2_mem_to_reg),
        .reg_write(w2_reg_write), .alu_src_a(w2_alu_src_a), .alu_src_b(w2_alu_src_b),
        .alu_op(w2_alu_op), .pc_source(w2_pc_source), .instr_count(w2_count), .trap(w2_trap)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one instruction from FETCH, stall its data access, score latency and retire count.
    task automatic run_instr(input logic [5:0] op, input logic z, input int stalls, input int exp_cyc);
        exp_t        e;
        logic [31:0] start;
        int          left, cyc;
        bit          done;
        sb_q.push_back('{exp_cyc, exp_count + 32'd1});
        exp_count = exp_count + 32'd1;
        opcode = op; zero = z;
        saw_rd_wr = 0; saw_mdr_wr = 0; saw_br_pc = 0; saw_j_pc = 0; saw_both_mem = 0;
        start = instr_count; left = stalls; cyc = 0; done = 0;
        while (!done && cyc < 30) begin
            mem_ready = 1'b1;
            if (i_or_d && (mem_read || mem_write) && left > 0) begin
                mem_ready = 1'b0;
                left--;
            end
            #1;
            if (reg_write && reg_dst)             saw_rd_wr = 1;
            if (reg_write && mem_to_reg)          saw_mdr_wr = 1;
            if (pc_en && pc_source == 2'b01)      saw_br_pc = 1;
            if (pc_en && pc_source == 2'b10)      saw_j_pc = 1;
            if (mem_read && mem_write)            saw_both_mem = 1;
            step();
            cyc++;
            if (instr_count !== start) done = 1;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (!done || cyc != e.cycles) begin
            n_fail++;
            $display("FAIL latency op=%02h: got %0d cycles (retired=%0d), expected %0d", op, cyc, done, e.cycles);
        end
        n_checks++;
        if (instr_count !== e.count) begin
            n_fail++;
            $display("FAIL retire_count op=%02h: got %0h, expected %0h", op, instr_count, e.count);
        end
        n_checks++;
        if (saw_both_mem) begin
            n_fail++;
            $display("FAIL mem_exclusive op=%02h: got read&write=1, expected 0", op);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({mem_read, i_or_d, ir_write, pc_en, alu_src_a, alu_src_b, alu_op, pc_source} !== 11'b1_0_1_1_0_01_00_00) begin
            n_fail++;
            $display("FAIL reset_fetch_decode: got %b, expected %b",
                     {mem_read, i_or_d, ir_write, pc_en, alu_src_a, alu_src_b, alu_op, pc_source}, 11'b1_0_1_1_0_01_00_00);
        end
        n_checks++;
        if ({mem_write, reg_write, reg_dst, mem_to_reg, trap, instr_count} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_zeroes: got %h, expected 0", {mem_write, reg_write, reg_dst, mem_to_reg, trap, instr_count});
        end
        reset = 1'b0;
        exp_count = 32'd0;
    endtask

    task automatic test_fetch_stall();
        mem_ready = 1'b0; #1;
        n_checks++;
        if ({mem_read, ir_write, pc_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL fetch_stall_gating: got %b, expected 100", {mem_read, ir_write, pc_en});
        end
        step(); step();
        n_checks++;
        if (instr_count !== exp_count || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_stall_hold: got count=%0h rd=%b, expected %0h 1", instr_count, mem_read, exp_count);
        end
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 1'b0, 0, 4);
        n_checks++;
        if (!saw_rd_wr) begin
            n_fail++;
            $display("FAIL rtype_wb: got reg_dst&reg_write=0, expected 1");
        end
    endtask

    task automatic test_lw_stall();
        run_instr(6'h23, 1'b0, 2, 7);
        n_checks++;
        if (!saw_mdr_wr) begin
            n_fail++;
            $display("FAIL lw_mem_to_reg: got 0, expected 1");
        end
    endtask

    task automatic test_beq();
        run_instr(6'h04, 1'b1, 0, 3);
        n_checks++;
        if (!saw_br_pc) begin
            n_fail++;
            $display("FAIL beq_taken_pc_en: got 0, expected 1");
        end
        run_instr(6'h04, 1'b0, 0, 3);
        n_checks++;
        if (saw_br_pc) begin
            n_fail++;
            $display("FAIL beq_not_taken_pc_en: got 1, expected 0");
        end
    endtask

    task automatic test_back_to_back();
        run_instr(6'h08, 1'b0, 0, 4);
        run_instr(6'h02, 1'b0, 0, 3);
        n_checks++;
        if (!saw_j_pc) begin
            n_fail++;
            $display("FAIL jump_pc_en: got 0, expected 1");
        end
        run_instr(6'h23, 1'b0, 0, 5);
        run_instr(6'h2B, 1'b0, 1, 5);
        run_instr(6'h00, 1'b0, 0, 4);
    endtask

    task automatic test_sw_reset_abort();
        int guard;
        opcode = 6'h2B; mem_ready = 1'b1; guard = 0;
        #1;
        while (!mem_write && guard < 10) begin
            step(); #1;
            guard++;
        end
        mem_ready = 1'b0;
        step(); #1;
        n_checks++;
        if (mem_write !== 1'b1 || instr_count === 32'd0) begin
            n_fail++;
            $display("FAIL sw_hold: got mem_write=%b count=%0h, expected 1 and nonzero", mem_write, instr_count);
        end
        reset = 1'b1; #1;
        n_checks++;
        if ({mem_write, mem_read, i_or_d, instr_count} !== {3'b010, 32'd0}) begin
            n_fail++;
            $display("FAIL sw_reset_abort: got wr=%b rd=%b iod=%b cnt=%0h, expected 0 1 0 0",
                     mem_write, mem_read, i_or_d, instr_count);
        end
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1;
        exp_count = 32'd0;
    endtask

    task automatic test_illegal();
`ifdef MC_TRAP_EN
        logic [31:0] before;
        before = instr_count;
        opcode = 6'h3F; mem_ready = 1'b1;
        repeat (4) step();
        #1;
        n_checks++;
        if ({trap, mem_read, mem_write, pc_en, reg_write, ir_write} !== 6'b100000 || instr_count !== before) begin
            n_fail++;
            $display("FAIL trap_hold: got trap=%b rd=%b wr=%b pc=%b rw=%b cnt=%0h, expected 1 0 0 0 0 %0h",
                     trap, mem_read, mem_write, pc_en, reg_write, instr_count, before);
        end
        reset = 1'b1; #1;
        n_checks++;
        if (trap !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_clear: got %b, expected 0", trap);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_count = 32'd0;
`else
        run_instr(6'h3F, 1'b0, 0, 2);
        n_checks++;
        if (trap !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_no_trap: got %b, expected 0", trap);
        end
`endif
    endtask

    // Narrow counter instance: seven jumps reach all-ones, the eighth wraps to zero.
    task automatic test_wrap();
        w2_reset = 1'b1; w2_opcode = 6'h02; w2_zero = 1'b0; w2_ready = 1'b1;
        @(negedge clk);
        w2_reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            logic [2:0] want;
            want = 3'(i);
            repeat (3) step();
            n_checks++;
            if (w2_count !== want) begin
                n_fail++;
                $display("FAIL count_wrap retire %0d: got %0d, expected %0d", i, w2_count, want);
            end
        end
    endtask

    initial begin
        w2_reset = 1'b1; w2_opcode = 6'h02; w2_zero = 1'b0; w2_ready = 1'b1;
        test_reset();
        test_fetch_stall();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_sw_reset_abort();
        test_rtype();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
